// File: rtl/instruction_fetch_stage_pkg.sv
// rtl/instruction_fetch_stage_pkg.sv - shared FSM encoding and fetch constants
package instruction_fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// rtl/instruction_fetch_stage_if_id_reg.sv - IF/ID pipeline register with hold and clear
module if_id_reg
  import instruction_fetch_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             clear,
  input  logic [WIDTH-1:0] pc_in,
  input  logic [WIDTH-1:0] instr_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out
);

  // Clear wins over hold so a flush can bubble a stalled entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= '0;
      instr_out <= WIDTH'(NOP_INSTR);
      valid_out <= 1'b0;
    end else if (clear) begin
      pc_out    <= '0;
      instr_out <= WIDTH'(NOP_INSTR);
      valid_out <= 1'b0;
    end else if (!hold) begin
      pc_out    <= pc_in;
      instr_out <= instr_in;
      valid_out <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, fetch FSM, IF/ID register
// Optional feature macro: IF_ALIGN_CHECK_EN (adds fetch_abort, word-aligns branch targets)
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               IMEM_LENGTH = 1024,
  parameter int               IMEM_AW     = $clog2(IMEM_LENGTH),
  parameter logic [WIDTH-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [WIDTH-1:0]   branch_addr,
  input  logic               flush,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [WIDTH-1:0]   imem_data,
  output logic [WIDTH-1:0]   pc_out,
  output logic [WIDTH-1:0]   instr_out,
  output logic               valid_out,
`ifdef IF_ALIGN_CHECK_EN
  output logic               fetch_abort,
`endif
  output logic [1:0]         fetch_state
);

  fetch_state_t     state, state_next;
  logic [WIDTH-1:0] pc, pc_next, pc_plus4, branch_target;
  logic             pc_load, id_hold, id_clear;

  assign pc_plus4    = pc + WIDTH'(WORD_BYTES);
  assign imem_addr   = pc[IMEM_AW+1:2];
  assign fetch_state = state;

`ifdef IF_ALIGN_CHECK_EN
  assign branch_target = {branch_addr[WIDTH-1:2], 2'b00};
`else
  assign branch_target = branch_addr;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_BOOT;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN, ST_HOLD: begin
        if (branch_taken)  state_next = ST_RUN;
        else if (freeze)   state_next = ST_HOLD;
        else               state_next = ST_RUN;
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // BOOT leaves everything parked; RUN and HOLD share one priority chain.
  always_comb begin
    pc_load  = 1'b0;
    pc_next  = pc;
    id_hold  = 1'b1;
    id_clear = 1'b0;
    case (state)
      ST_RUN, ST_HOLD: begin
        if (branch_taken) begin
          pc_load  = 1'b1;
          pc_next  = branch_target;
          id_clear = 1'b1;
        end else if (freeze) begin
          id_clear = flush;
        end else begin
          pc_load  = 1'b1;
          pc_next  = pc_plus4;
          id_hold  = 1'b0;
          id_clear = flush;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          pc <= RESET_PC;
    else if (pc_load) pc <= pc_next;
  end

  if_id_reg #(.WIDTH(WIDTH)) u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .hold      (id_hold),
    .clear     (id_clear),
    .pc_in     (pc_plus4),
    .instr_in  (imem_data),
    .pc_out    (pc_out),
    .instr_out (instr_out),
    .valid_out (valid_out)
  );

`ifdef IF_ALIGN_CHECK_EN
  logic abort_pending;
  logic load_valid;

  assign load_valid = !id_hold && !id_clear;

  // The abort rides with the first real instruction fetched from the corrected target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abort_pending <= 1'b0;
      fetch_abort   <= 1'b0;
    end else begin
      fetch_abort <= abort_pending && load_valid;
      if (state != ST_BOOT && branch_taken) abort_pending <= |branch_addr[1:0];
      else if (load_valid)                  abort_pending <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the ARM968E-S pipeline. Holds the PC, drives the word address into the asynchronous instruction ROM (combinational read, data valid in the same cycle), and captures the returned instruction into the IF/ID pipeline register. Handles hazard freeze, taken-branch redirect and pipeline flush. Sits directly upstream of the instruction memory and feeds the ID stage.

Parameters:
WIDTH, 32, instruction/PC data width
IMEM_LENGTH, 1024, instruction ROM depth in words (power of two)
IMEM_AW, $clog2(IMEM_LENGTH), ROM word-address width (derived)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
freeze  input  1  hazard stall from hazard unit; holds PC and IF/ID
branch_taken  input  1  taken branch resolved in EX
branch_addr  input  WIDTH  branch target byte address
flush  input  1  invalidate IF/ID contents (bubble)
imem_addr  output  IMEM_AW  word address to instruction ROM = pc[IMEM_AW+1:2]
imem_data  input  WIDTH  instruction from ROM, same-cycle
pc_out  output  WIDTH  IF/ID: fetched PC + 4
instr_out  output  WIDTH  IF/ID: fetched instruction
valid_out  output  1  IF/ID: entry holds a real instruction
fetch_state  output  2  current FSM state (debug)

Behaviour:
- Reset (async, any time, incl. mid-stall/branch): pc=RESET_PC, pc_out=0, instr_out=0, valid_out=0, state=BOOT. Takes effect immediately, not at next edge.
- imem_addr purely combinational from pc; upper PC bits ignored, index wraps modulo IMEM_LENGTH.
- FSM states: BOOT=2'd0, RUN=2'd1, HOLD=2'd2.
- BOOT: one cycle after reset release; no PC update, IF/ID stays invalid; -> RUN unconditionally (branch/freeze/flush ignored).
- RUN: priority per edge: branch_taken > freeze > normal.
  - branch_taken: pc<=branch_addr; IF/ID <= bubble (instr_out=0, pc_out=0, valid_out=0); stay RUN. Overrides freeze and flush.
  - freeze (no branch): pc, pc_out, instr_out, valid_out hold; -> HOLD. If flush also high, IF/ID becomes bubble, pc still holds.
  - normal: pc<=pc+4 (wraps mod 2^WIDTH); instr_out<=imem_data; pc_out<=pc+4; valid_out<=1. If flush high, pc still advances but IF/ID <= bubble.
- HOLD: same priority rules as RUN; exits to RUN on first edge with freeze low or branch_taken high.
- Latency: instruction at pc appears on instr_out 1 cycle after pc presents it; first valid_out two edges after reset release.
- freeze held indefinitely: outputs stable, no PC drift.

Optional Feature:
IF_ALIGN_CHECK_EN: when defined, adds output fetch_abort (1 bit, reset 0). On branch_taken with branch_addr[1:0]!=0, pc loads {branch_addr[WIDTH-1:2],2'b00} and fetch_abort pulses high for exactly one cycle together with the following valid IF/ID entry. Undefined: no port, branch_addr loaded verbatim; low bits only affect pc+4 arithmetic, never imem_addr.

Decomposition:
- Shared package: FSM state encoding constants (BOOT/RUN/HOLD), NOP_INSTR=32'h0, word-size constant 4.
- One natural sub-module: if_id_reg (IF/ID pipeline register with hold and clear inputs, async reset); PC/FSM logic in top.

Test Plan:
- Reset then run, ROM word k = 32'hE000_0000+k: after reset release, valid_out low 2 edges, then instr_out E0000000, E0000001, E0000002 on consecutive cycles, pc_out 4,8,12.
- freeze high 3 cycles when pc=8: imem_addr stays 2, instr_out/pc_out unchanged, fetch_state=HOLD; on release fetch resumes at word 2 with no skip/duplicate.
- branch_taken with branch_addr=0x40 while freeze high: next edge pc=0x40, valid_out=0; following edge instr_out=ROM[16], pc_out=0x44.
- flush alone at pc=0x10: IF/ID bubble (valid_out=0, instr_out=0), pc advances to 0x14, next instruction ROM[5].
- Assert rst mid-freeze at pc=0x20: pc, outputs clear without clock edge; state BOOT; refetch from 0.
- With IF_ALIGN_CHECK_EN, branch to 0x42: pc=0x40, fetch_abort high exactly one cycle alongside instr_out=ROM[16]; without macro, pc=0x42, imem_addr=16, pc_out=0x46.
